// File: rtl/mem_dbus_ctrl_if.sv
// mem_dbus_ctrl_if: data-bus request/response signals between the memory stage and the bus slave
interface mem_dbus_ctrl_if;
   logic        valid;
   logic [63:0] addr;
   logic [1:0]  size;
   logic [7:0]  strobe;
   logic [63:0] data;
   logic        addr_ok;
   logic        data_ok;
   logic [63:0] rdata;
   modport master (output valid, addr, size, strobe, data, input addr_ok, data_ok, rdata);
   modport slave (input valid, addr, size, strobe, data, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: memory-stage dbus master, one transaction per load/store, aligned/extended load result
module mem_dbus_ctrl (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_valid,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [1:0]   mem_size,
   input  logic         mem_unsigned,
   input  logic [63:0]  addr,
   input  logic [63:0]  wdata,
   input  logic         advance,
   input  logic         flush,
   mem_dbus_ctrl_if.master dbus,
   output logic [63:0]  rdata,
   output logic         done,
   output logic         misalign,
   output logic         stall_req,
   output logic         dbus_not_busy
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state, nxt;
   logic kill, kill_now, start, fin;
   logic [63:0] l_addr, l_data, cur_addr, sh, load_res;
   logic [1:0] l_size, cur_size;
   logic [7:0] l_strobe, cur_strobe, smask;
   logic l_unsigned, cur_unsigned, sx;
   logic [2:0] amask;
   assign amask = {mem_size == 2'd3, mem_size[1], |mem_size};
   assign misalign = |(addr[2:0] & amask);
   assign start = mem_valid & (mem_read | mem_write) & ~misalign & (state == IDLE);
   assign smask = mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF;
   // In IDLE the request goes out straight from the pipeline register; afterwards from the latch
   assign cur_addr = state == IDLE ? addr : l_addr;
   assign cur_size = state == IDLE ? mem_size : l_size;
   assign cur_strobe = state == IDLE ? (mem_write ? smask << addr[2:0] : 8'h00) : l_strobe;
   assign cur_unsigned = state == IDLE ? mem_unsigned : l_unsigned;
   assign dbus.valid = start | (state == REQ);
   assign dbus.addr = cur_addr;
   assign dbus.size = cur_size;
   assign dbus.strobe = cur_strobe;
   assign dbus.data = state == IDLE ? wdata << {addr[2:0], 3'b000} : l_data;
   assign sh = dbus.rdata >> {cur_addr[2:0], 3'b000};
   assign sx = ~cur_unsigned;
   assign load_res = cur_size == 2'd0 ? {{56{sx & sh[7]}}, sh[7:0]} :
                     cur_size == 2'd1 ? {{48{sx & sh[15]}}, sh[15:0]} :
                     cur_size == 2'd2 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
   assign fin = ((start | (state == REQ)) & dbus.addr_ok & dbus.data_ok) | ((state == WAIT) & dbus.data_ok);
   assign stall_req = start | (state == REQ) | (state == WAIT);
   assign dbus_not_busy = ((state == IDLE) & ~start) | (state == DONE);
   assign kill_now = kill | (flush & stall_req);
   always_comb begin
      nxt = fin ? (kill_now ? IDLE : DONE) :
            ((start | (state == REQ)) & dbus.addr_ok) ? WAIT :
            start ? REQ :
            ((state == DONE) & (flush | advance)) ? IDLE : state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         kill <= 1'b0;
         l_addr <= '0;
         l_data <= '0;
         l_size <= '0;
         l_strobe <= '0;
         l_unsigned <= 1'b0;
         rdata <= '0;
         done <= 1'b0;
      end else begin
         state <= nxt;
         kill <= stall_req & ~fin & kill_now;
         done <= nxt == DONE;
         if (start) begin
            l_addr <= addr;
            l_data <= dbus.data;
            l_size <= mem_size;
            l_strobe <= cur_strobe;
            l_unsigned <= mem_unsigned;
         end
         // A killed transaction drains on the bus but never updates the result
         if (fin & ~kill_now) rdata <= cur_strobe == 8'h00 ? load_res : 64'h0;
      end
   end
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb_mem_dbus_ctrl: directed checks of the memory-stage dbus controller
module tb_mem_dbus_ctrl;
   logic clk = 1'b0, reset = 1'b1, mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic mem_unsigned = 1'b0, advance = 1'b0, flush = 1'b0;
   logic [1:0] mem_size = 2'd0;
   logic [63:0] addr = '0, wdata = '0, rdata;
   logic done, misalign, stall_req, dbus_not_busy;
   int checks = 0, failures = 0, nreq;
   mem_dbus_ctrl_if bus();
   mem_dbus_ctrl dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
      .advance(advance), .flush(flush), .dbus(bus), .rdata(rdata), .done(done),
      .misalign(misalign), .stall_req(stall_req), .dbus_not_busy(dbus_not_busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic op(input logic r, input logic w, input logic u, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
      mem_valid = 1'b1; mem_read = r; mem_write = w; mem_unsigned = u; mem_size = sz; addr = a; wdata = wd;
   endtask
   task automatic oks(input logic ao, input logic dok, input logic [63:0] rd);
      bus.addr_ok = ao; bus.data_ok = dok; bus.rdata = rd;
   endtask
   task automatic retire;
      advance = 1'b1; mem_valid = 1'b0;
      cyc;
      advance = 1'b0;
   endtask
   initial begin
      oks(1'b0, 1'b0, 64'h0);
      #1;
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_nb", dbus_not_busy, 1);
      cyc;
      reset = 1'b0;
      op(1, 0, 0, 2'd3, 64'h80000008, 64'h0);
      oks(1, 1, 64'h1122334455667788);
      #1;
      chk("ld_valid", bus.valid, 1);
      chk("ld_stall", stall_req, 1);
      chk("ld_nb", dbus_not_busy, 0);
      chk("ld_strobe", bus.strobe, 0);
      chk("ld_addr", bus.addr, 64'h80000008);
      chk("ld_size", bus.size, 3);
      cyc;
      oks(0, 0, 64'h0);
      #1;
      chk("ld_done", done, 1);
      chk("ld_rdata", rdata, 64'h1122334455667788);
      chk("ld_valid_off", bus.valid, 0);
      chk("ld_stall_off", stall_req, 0);
      chk("ld_nb_done", dbus_not_busy, 1);
      retire;
      #1;
      chk("ld_done_clr", done, 0);
      op(1, 0, 0, 2'd0, 64'h80000003, 64'h0);
      oks(1, 1, 64'h0000000080FF0000);
      cyc;
      oks(0, 0, 64'h0);
      #1;
      chk("lb_done", done, 1);
      chk("lb_rdata", rdata, 64'hFFFFFFFFFFFFFF80);
      retire;
      op(1, 0, 1, 2'd0, 64'h80000003, 64'h0);
      oks(1, 1, 64'h0000000080FF0000);
      cyc;
      oks(0, 0, 64'h0);
      #1;
      chk("lbu_rdata", rdata, 64'h80);
      retire;
      op(0, 1, 0, 2'd1, 64'h80000006, 64'hBEEF);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) oks(1, 1, 64'h0);
         #1;
         chk("sh_valid", bus.valid, 1);
         chk("sh_strobe", bus.strobe, 8'hC0);
         chk("sh_data", bus.data, 64'hBEEF000000000000);
         chk("sh_addr", bus.addr, 64'h80000006);
         chk("sh_stall", stall_req, 1);
         cyc;
         wdata = 64'h0;
      end
      oks(0, 0, 64'h0);
      #1;
      chk("sh_done", done, 1);
      chk("sh_rdata", rdata, 64'h0);
      retire;
      op(1, 0, 0, 2'd3, 64'h80000010, 64'h0);
      for (int i = 0; i < 5; i++) begin
         oks(i == 0, i == 4, 64'hDEADBEEFDEADBEEF);
         flush = (i == 2);
         #1;
         chk("fl_nb", dbus_not_busy, 0);
         chk("fl_stall", stall_req, 1);
         chk("fl_valid", bus.valid, {63'h0, i == 0});
         cyc;
      end
      flush = 1'b0;
      oks(0, 0, 64'h0);
      mem_valid = 1'b0;
      #1;
      chk("fl_done", done, 0);
      chk("fl_nb_after", dbus_not_busy, 1);
      chk("fl_rdata", rdata, 64'h0);
      op(1, 0, 0, 2'd2, 64'h80000002, 64'h0);
      oks(1, 1, 64'h0);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("mis_flag", misalign, 1);
         chk("mis_valid", bus.valid, 0);
         chk("mis_stall", stall_req, 0);
         chk("mis_nb", dbus_not_busy, 1);
         cyc;
      end
      chk("mis_done", done, 0);
      mem_valid = 1'b0;
      oks(0, 0, 64'h0);
      #1;
      op(1, 0, 1, 2'd2, 64'h80000004, 64'h0);
      oks(1, 1, 64'hCAFEBABE00000000);
      nreq = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         nreq += int'(bus.valid);
         cyc;
         if (i == 0) oks(0, 0, 64'h0);
      end
      chk("hold_nreq", 64'(nreq), 1);
      chk("hold_done", done, 1);
      chk("hold_rdata", rdata, 64'h00000000CAFEBABE);
      advance = 1'b1;
      cyc;
      advance = 1'b0;
      oks(1, 0, 64'h0);
      cyc;
      oks(0, 0, 64'h0);
      #1;
      chk("wt_stall", stall_req, 1);
      chk("wt_valid", bus.valid, 0);
      mem_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("ar_done", done, 0);
      chk("ar_rdata", rdata, 64'h0);
      chk("ar_valid", bus.valid, 0);
      chk("ar_stall", stall_req, 0);
      chk("ar_nb", dbus_not_busy, 1);
      cyc;
      reset = 1'b0;
      #1;
      chk("ar_release_nb", dbus_not_busy, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
